// File: rtl/program_sequencer.sv
// Program sequencer: feeds a small program memory to the bus CPU one instruction
// at a time, waits for done, and flags a CPU that stalls past the watchdog limit.
//
// state | meaning
// IDLE  | waiting for start, memory writable
// ISSUE | one-cycle run strobe with the opcode word on din
// IMM   | mvi immediate word on din, waiting for done
// WAIT  | single-word instruction in flight, waiting for done
// HALT  | program ran to completion, memory writable
// ERR   | watchdog expired, pc frozen until reset
module program_sequencer #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [2:0] MVI_OPC = 3'b001,
  parameter int         TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          done,
  output logic [15:0]   din,
  output logic          run,
  output logic [AW:0]   pc,
  output logic          busy,
  output logic          halted,
  output logic          error
);

  localparam int PW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, HALT, ERR} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   pc_nxt;
  logic [WW-1:0] wd, wd_nxt;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   mem_word;
  logic [AW:0]   pc_inc;
  logic          is_mvi;
  logic          wr_ok;

  assign mem_word = mem[pc[AW-1:0]];
  assign pc_inc   = pc + PW'(1);
  assign is_mvi   = (mem_word[15:13] == MVI_OPC);
  assign wr_ok    = (state == IDLE) || (state == HALT) || (state == ERR);

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      wd    <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wd_nxt    = wd;
    din       = '0;
    run       = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          if (prog_len == '0) begin
            state_nxt = HALT;
          end else begin
            state_nxt = ISSUE;
            pc_nxt    = '0;
            wd_nxt    = '0;
          end
        end
      end
      ISSUE: begin
        din = mem_word;
        run = 1'b1;
        if (is_mvi && (pc_inc < prog_len)) begin
          state_nxt = IMM;
          pc_nxt    = pc_inc;
        end else begin
          state_nxt = WAIT;
        end
      end
      IMM, WAIT: begin
        // An mvi left waiting in WAIT was the last word, so it has no immediate to show.
        din = (state == WAIT && is_mvi) ? 16'h0000 : mem_word;
        if (done) begin
          pc_nxt = pc_inc;
          if (pc_inc >= prog_len) begin
            state_nxt = HALT;
          end else begin
            state_nxt = ISSUE;
            wd_nxt    = '0;
          end
        end else begin
          wd_nxt = wd + WW'(1);
          if (wd == WD_LAST) state_nxt = ERR;
        end
      end
      default: ;
    endcase
  end

  assign busy   = (state == ISSUE) || (state == IMM) || (state == WAIT);
  assign halted = (state == HALT);
  assign error  = (state == ERR);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a fixed-latency CPU responder that
// raises done a set number of cycles after each run strobe.
module tb_program_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, wr_en, start, done;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data, din;
  logic [AW:0]   prog_len, pc;
  logic          run, busy, halted, error;

  int checks = 0;
  int failures = 0;
  int runs = 0;
  int cnt = 0;
  int lat = 1;
  bit cpu_en = 1'b1;
  logic [AW:0] pc_last;
  logic [AW:0] pc_hist [$];
  int n;

  program_sequencer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .prog_len(prog_len), .done(done), .din(din), .run(run),
    .pc(pc), .busy(busy), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then update the CPU model from the post-edge outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) done = 1'b1;
    end
    if (run) begin
      runs++;
      if (cpu_en) cnt = lat;
    end
    if (pc != pc_last) begin
      pc_hist.push_back(pc);
      pc_last = pc;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    done = 1'b0;
  endtask

  task automatic wait_for(input bit want_err, output int k);
    k = 0;
    while (!(want_err ? error : halted) && k < 100) begin
      tick();
      k++;
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; prog_len = '0; done = 1'b0; pc_last = '0;
    tick();
    do_reset();
    chk("rst_din", din, 0);
    chk("rst_run", run, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", {busy, halted, error}, 3'b000);

    // single mv, done 3 cycles after run
    wr(0, 16'h0000);
    prog_len = 1; lat = 3; runs = 0;
    pulse_start();
    chk("t1_run", run, 1);
    chk("t1_din", din, 16'h0000);
    chk("t1_busy", busy, 1);
    wait_for(0, n);
    chk("t1_cycles_to_halt", n, 4);
    chk("t1_runs", runs, 1);
    chk("t1_pc", pc, 1);
    chk("t1_busy_end", busy, 0);

    // mvi + immediate
    wr(0, 16'h2000);
    wr(1, 16'h00A5);
    prog_len = 2; lat = 2; runs = 0;
    pulse_start();
    chk("t2_run", run, 1);
    chk("t2_din_op", din, 16'h2000);
    tick();
    chk("t2_din_imm", din, 16'h00A5);
    chk("t2_pc_imm", pc, 1);
    chk("t2_run_imm", run, 0);
    wait_for(0, n);
    chk("t2_cycles_to_halt", n, 2);
    chk("t2_runs", runs, 1);
    chk("t2_pc", pc, 2);

    // mv, mvi, imm
    wr(0, 16'h0000);
    wr(1, 16'h2000);
    wr(2, 16'h00A5);
    prog_len = 3; lat = 1; runs = 0;
    pc_hist.delete();
    pc_last = 5'h1f;
    pulse_start();
    wait_for(0, n);
    chk("t3_halted", halted, 1);
    chk("t3_runs", runs, 2);
    chk("t3_pc_hist_len", pc_hist.size(), 4);
    for (int i = 0; i < 4 && i < pc_hist.size(); i++)
      chk($sformatf("t3_pc_hist%0d", i), pc_hist[i], i);

    // mvi at the last address behaves as a one-word instruction
    wr(0, 16'h2000);
    prog_len = 1; lat = 2; runs = 0;
    pulse_start();
    chk("t4_din_op", din, 16'h2000);
    tick();
    chk("t4_wait_din", din, 16'h0000);
    chk("t4_wait_pc", pc, 0);
    wait_for(0, n);
    chk("t4_runs", runs, 1);
    chk("t4_pc", pc, 1);

    // full-depth program halts without pc wrap
    for (int i = 0; i < 16; i++) wr(AW'(i), 16'h0000);
    prog_len = 16; lat = 1; runs = 0;
    pulse_start();
    wait_for(0, n);
    chk("t5_halted", halted, 1);
    chk("t5_runs", runs, 16);
    chk("t5_pc", pc, 16);

    // watchdog
    wr(0, 16'h1234);
    prog_len = 1; cpu_en = 1'b0; runs = 0;
    pulse_start();
    wait_for(1, n);
    chk("t6_cycles_to_err", n, 16);
    chk("t6_error", error, 1);
    chk("t6_pc", pc, 0);
    chk("t6_busy", busy, 0);
    chk("t6_din", din, 0);
    pulse_start();
    tick();
    chk("t6_err_hold", error, 1);
    chk("t6_runs", runs, 1);
    do_reset();
    chk("t6_err_clear", error, 0);
    cpu_en = 1'b1;

    // write and start while busy are ignored
    wr(0, 16'h0000);
    prog_len = 1; lat = 3; runs = 0;
    pulse_start();
    start = 1'b1; wr_en = 1'b1; wr_addr = 0; wr_data = 16'hFFFF;
    tick();
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_for(0, n);
    chk("t7_runs", runs, 1);
    pulse_start();
    chk("t7_din_rerun", din, 16'h0000);
    wait_for(0, n);

    // reset in WAIT
    lat = 5;
    pulse_start();
    tick();
    chk("t8_in_wait", busy, 1);
    do_reset();
    chk("t8_din", din, 0);
    chk("t8_run", run, 0);
    chk("t8_pc", pc, 0);
    chk("t8_flags", {busy, halted, error}, 3'b000);

    // start coincident with a write in IDLE sees the new word
    prog_len = 1; lat = 1;
    wr_en = 1'b1; wr_addr = 0; wr_data = 16'h0ABC; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("t9_run", run, 1);
    chk("t9_din", din, 16'h0ABC);
    wait_for(0, n);

    // prog_len = 0 halts without issuing
    do_reset();
    prog_len = 0; runs = 0;
    pulse_start();
    tick();
    tick();
    chk("t10_halted", halted, 1);
    chk("t10_runs", runs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Upstream feeder for the 16-bit bus CPU.
- Holds a small program memory, drives the CPU `din` and `run` inputs one instruction at a time, and presents the immediate word for mvi.
- Waits for the CPU `done` before issuing the next instruction.
- Provides a load port, a start/halt control, and a watchdog that flags a CPU that never completes.

Parameters:
- DEPTH, 16, program memory depth in 16-bit words (power of two, ≥ 2).
- AW, 4, address/PC width, equals log2(DEPTH).
- MVI_OPC, 3'b001, value of din[15:13] that marks an mvi (two-word) instruction.
- TIMEOUT, 15, maximum cycles spent waiting for `done` before the error state is entered.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  program memory write strobe
- wr_addr  in  AW  write address
- wr_data  in  16  write data
- start  in  1  one-cycle pulse that begins execution at address 0
- prog_len  in  AW+1  number of words to execute (1..DEPTH); 0 means halt immediately
- done  in  1  CPU instruction complete, combinational from the CPU control unit
- din  out  16  instruction/immediate word to the CPU
- run  out  1  one-cycle instruction-issue strobe to the CPU
- pc  out  AW+1  address of the current instruction word
- busy  out  1  high in ISSUE, IMM and WAIT
- halted  out  1  program finished normally
- error  out  1  watchdog expired

Behaviour:
- Reset values: din = 0, run = 0, pc = 0, busy = 0, halted = 0, error = 0, state = IDLE, watchdog = 0. Memory contents are not reset.
- Memory write:
  - Synchronous; takes effect only when state is IDLE, HALT or ERR.
  - wr_en is ignored in all other states.
  - Read is asynchronous: din = mem[pc] while the sequencer is driving.
- States: IDLE, ISSUE, IMM, WAIT, HALT, ERR.
- IDLE:
  - din = 0, run = 0.
  - start with prog_len = 0 -> HALT.
  - start with prog_len ≠ 0 -> pc = 0, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - din = mem[pc], run = 1.
  - If din[15:13] == MVI_OPC and pc+1 < prog_len -> go to IMM, pc = pc+1.
  - Otherwise -> go to WAIT.
  - An mvi at the last address is treated as a one-word instruction; din reads 0 during WAIT.
- IMM:
  - din = mem[pc] (the immediate), run = 0.
  - Sampling done: same as WAIT.
- WAIT:
  - din = mem[pc] for a non-mvi instruction (held stable), run = 0.
  - done = 1 -> pc = pc+1.
    - If the new pc ≥ prog_len -> HALT.
    - Else -> ISSUE on the next cycle. Minimum issue-to-issue gap is therefore the CPU latency + 1.
  - done = 0 -> watchdog += 1. When the watchdog reaches TIMEOUT without done -> ERR.
- Watchdog clears on every entry to ISSUE. It counts in both IMM and WAIT.
- done in IMM: treated as in WAIT (pc advances past the immediate).
- done while in IDLE, ISSUE, HALT or ERR: ignored.
- HALT: halted = 1, busy = 0, din = 0. start -> clear halted, restart as from IDLE.
- ERR: error = 1, busy = 0, din = 0, pc frozen for debug. Only reset leaves ERR; start is ignored.
- start while busy: ignored.
- start coincident with wr_en in IDLE: the write completes and execution begins. The first ISSUE reads the new data if wr_addr = 0.
- reset mid-program: synchronous reset has priority over every other input in that cycle; all outputs return to reset values on the next edge.
- pc arithmetic is AW+1 bits, so prog_len = DEPTH halts cleanly without wrap.

Test Plan:
- Load mem[0] = 16'h0000 (mv), prog_len = 1, pulse start, return done 3 cycles after run -> run high exactly 1 cycle with din = 16'h0000; pc becomes 1; halted = 1 the cycle after done; busy = 0.
- Load mem[0] = 16'h2000 (mvi), mem[1] = 16'h00A5, prog_len = 2, done 2 cycles after run -> din = 16'h2000 with run = 1, next cycle din = 16'h00A5, pc = 1; halted after done; only one run pulse.
- Three-word program {mv, mvi + imm} with prog_len = 3 -> exactly 2 run pulses; pc sequence 0, 1, 2, 3; halted = 1.
- Never assert done after run with TIMEOUT = 15 -> error = 1 after 15 waiting cycles; pc stays 0; a start pulse in ERR has no effect; reset clears error.
- Assert wr_en to address 0 while busy -> mem[0] unchanged on a rerun. Assert start while busy -> no second run pulse.
- Assert reset in WAIT -> the next cycle shows all outputs 0 and state IDLE; start with prog_len = 0 -> halted = 1, run never asserted.
